sram_dp_port_arbiter: RTL

//  Shares one port of the 512x36 dual-port SRAM wrapper between NUM_REQ requesters
//  (e.g. CPU and DMA) using round-robin, one access per cycle.

---
 rtl/sram_dp_port_arbiter_pkg.sv | 24 ++
 rtl/sram_dp_port_arbiter_rr.sv | 37 +++
 rtl/sram_dp_port_arbiter.sv | 124 ++++++++++++
 3 files changed

// File: rtl/sram_dp_port_arbiter_pkg.sv
// Shared types and helpers for the SRAM port arbiter: FSM encoding, default geometry
// and a one-hot to binary index converter sized for the widest supported requester count.
package sram_arb_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } arb_state_e;

    localparam int DEF_ADDR_W = 9;
    localparam int DEF_DATA_W = 36;
    localparam int DEF_DEPTH  = 512;
    localparam int MAX_REQ    = 4;

    function automatic logic [1:0] onehot2idx(input logic [MAX_REQ-1:0] oh);
        logic [1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (oh[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/sram_dp_port_arbiter_rr.sv
// Combinational round-robin picker: grants the first asserted request at or after ptr,
// wrapping modulo NUM_REQ, and reports the winner both one-hot and as a binary index.
module sram_rr_arbiter
    import sram_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = (NUM_REQ > 2) ? 2 : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [PTR_W-1:0]   idx
);

    logic [MAX_REQ-1:0] gnt_pad;

    // Scan from the farthest offset back to ptr so the closest valid requester wins last.
    always_comb begin
        int j;
        j   = 0;
        gnt = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % NUM_REQ;
            if (req[j]) begin
                gnt    = '0;
                gnt[j] = 1'b1;
            end
        end
    end

    always_comb begin
        gnt_pad                = '0;
        gnt_pad[NUM_REQ-1:0]   = gnt;
        idx                    = PTR_W'(onehot2idx(gnt_pad));
    end

endmodule

// File: rtl/sram_dp_port_arbiter.sv
// Shares one SRAM port among NUM_REQ requesters with round-robin arbitration, returns
// tagged read data one cycle after acceptance, and sweeps INIT_VALUE through the array.
module sram_dp_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int                NUM_REQ       = 2,
    parameter int                ADDR_W        = DEF_ADDR_W,
    parameter int                DATA_W        = DEF_DATA_W,
    parameter int                DEPTH         = DEF_DEPTH,
    parameter bit                INIT_ON_RESET = 1'b1,
    parameter logic [DATA_W-1:0] INIT_VALUE    = '0
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ-1:0]          req_we,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_adr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic [NUM_REQ-1:0]          rsp_valid,
    output logic [DATA_W-1:0]           rsp_rdata,
    input  logic                        init_start,
    output logic                        init_done,
    output logic                        mem_me,
    output logic                        mem_we,
    output logic [ADDR_W-1:0]           mem_adr,
    output logic [DATA_W-1:0]           mem_d,
    input  logic [DATA_W-1:0]           mem_q
);

    localparam int PTR_W = (NUM_REQ > 2) ? 2 : 1;
    localparam arb_state_e RESET_ST = INIT_ON_RESET ? ST_INIT : ST_RUN;

    arb_state_e          state_q, state_d;
    logic [ADDR_W-1:0]   init_cnt_q, init_cnt_d;
    logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rdata_hold_q;

    logic [NUM_REQ-1:0]  gnt;
    logic [PTR_W-1:0]    gnt_idx;
    logic [NUM_REQ-1:0]  ready_c;
    logic                me_c, we_c;

    logic [ADDR_W-1:0]   adr_arr   [NUM_REQ];
    logic [DATA_W-1:0]   wdata_arr [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign adr_arr[gi]   = req_adr[gi*ADDR_W +: ADDR_W];
        assign wdata_arr[gi] = req_wdata[gi*DATA_W +: DATA_W];
    end

    sram_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr (
        .req (req_valid),
        .ptr (rr_ptr_q),
        .gnt (gnt),
        .idx (gnt_idx)
    );

    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        rr_ptr_d    = rr_ptr_q;
        rsp_valid_d = '0;
        ready_c     = '0;
        me_c        = 1'b0;
        we_c        = 1'b0;
        mem_adr     = '0;
        mem_d       = '0;
        case (state_q)
            ST_INIT: begin
                me_c       = 1'b1;
                we_c       = 1'b1;
                mem_adr    = init_cnt_q;
                mem_d      = INIT_VALUE;
                init_cnt_d = init_cnt_q + 1'b1;
                if (init_cnt_q == ADDR_W'(DEPTH - 1)) begin
                    state_d    = ST_RUN;
                    init_cnt_d = '0;
                end
            end
            ST_RUN: begin
                ready_c = gnt;
                if (|gnt) begin
                    me_c     = 1'b1;
                    we_c     = req_we[gnt_idx];
                    mem_adr  = adr_arr[gnt_idx];
                    mem_d    = wdata_arr[gnt_idx];
                    rr_ptr_d = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
                    if (!req_we[gnt_idx]) rsp_valid_d = gnt;
                end
                if (init_start) state_d = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= RESET_ST;
            init_cnt_q   <= '0;
            rr_ptr_q     <= '0;
            rsp_valid_q  <= '0;
            rdata_hold_q <= '0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            rr_ptr_q    <= rr_ptr_d;
            rsp_valid_q <= rsp_valid_d;
            if (|rsp_valid_q) rdata_hold_q <= mem_q;
        end
    end

    // The port strobes are gated by reset_n so the SRAM sees no access while reset is held.
    assign mem_me    = me_c & reset_n;
    assign mem_we    = we_c & reset_n;
    assign req_ready = ready_c & {NUM_REQ{reset_n}};
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = (|rsp_valid_q) ? mem_q : rdata_hold_q;
    assign init_done = (state_q == ST_RUN);

endmodule
